// File: rtl/nbr64_eval_ctrl.sv
// Sequencing controller for a 64-bit bistable-ring PUF: N evaluations per challenge, majority vote.
// Optional all-evaluations-agree flag (rsp_stable) is built when NBR_STABILITY_EN is defined.
module nbr64_eval_ctrl #(
    parameter int RESET_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int NUM_EVAL      = 5,
    parameter int CNT_W         = $clog2(NUM_EVAL + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_challenge,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_bit,
    output logic [CNT_W-1:0] rsp_ones,
`ifdef NBR_STABILITY_EN
    output logic             rsp_stable,
`endif
    output logic             PUF_RESET,
    output logic [63:0]      PUF_C,
    input  logic             PUF_OUT
);

    localparam int CYC_MAX = (RESET_CYCLES > SETTLE_CYCLES) ?
                             RESET_CYCLES : SETTLE_CYCLES;
    localparam int CYC_W = $clog2(CYC_MAX + 1);

    localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RESET_CYCLES - 1);
    localparam logic [CYC_W-1:0] SET_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(NUM_EVAL - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(NUM_EVAL / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic [CYC_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_eval;
    logic [CNT_W-1:0] r_ones;
    logic [63:0]      r_puf_c;
    logic             r_puf_reset;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic             r_meta;
    logic             r_sync;
    logic             w_accept;
    logic             w_timed;

    // PUF_OUT is asynchronous; no reset so the flops never mask a metastable edge
    always_ff @(posedge CLK) begin
        r_meta <= PUF_OUT;
        r_sync <= r_meta;
    end

    always_comb begin
        w_nxt    = r_state;
        w_accept = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_nxt    = S_RST;
                    w_accept = 1'b1;
                end
            end
            S_RST: begin
                if (r_cyc == RST_LAST) w_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cyc == SET_LAST) w_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_nxt = (r_eval == EVAL_LAST) ? S_DONE : S_RST;
            end
            S_DONE: begin
                if (r_rsp_valid && rsp_ready) w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    assign w_timed = (r_state == S_RST) || (r_state == S_SETTLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_eval      <= '0;
            r_ones      <= '0;
            r_puf_c     <= '0;
            r_puf_reset <= 1'b1;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_puf_reset <= (w_nxt != S_SETTLE);
            r_req_ready <= (w_nxt == S_IDLE);
            r_rsp_valid <= (w_nxt == S_DONE);
            if (w_timed && (w_nxt == r_state)) begin
                r_cyc <= r_cyc + 1'b1;
            end else begin
                r_cyc <= '0;
            end
            if (w_accept) begin
                r_puf_c <= req_challenge;
                r_ones  <= '0;
                r_eval  <= '0;
            end else if (r_state == S_SAMPLE) begin
                r_ones <= r_ones + CNT_W'(r_sync);
                r_eval <= r_eval + 1'b1;
            end
        end
    end

`ifdef NBR_STABILITY_EN
    logic r_first;
    logic r_mis;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_first <= 1'b0;
            r_mis   <= 1'b0;
        end else if (w_accept) begin
            r_first <= 1'b0;
            r_mis   <= 1'b0;
        end else if (r_state == S_SAMPLE) begin
            if (r_eval == '0) begin
                r_first <= r_sync;
            end else if (r_sync != r_first) begin
                r_mis <= 1'b1;
            end
        end
    end

    assign rsp_stable = r_rsp_valid && !r_mis;
`endif

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_bit   = r_rsp_valid && (r_ones > HALF);
    assign rsp_ones  = r_ones;
    assign PUF_RESET = r_puf_reset;
    assign PUF_C     = r_puf_c;

endmodule

// File: tb/tb_nbr64_eval_ctrl.sv
// Bench for nbr64_eval_ctrl: default instance plus a minimal-parameter instance.
// Expected responses are queued at request time and popped when rsp_valid shows.
module tb_nbr64_eval_ctrl;

    localparam int R   = 4;
    localparam int S   = 16;
    localparam int N   = 5;
    localparam int EV  = R + S + 1;
    localparam int LAT = N * EV + 1;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_challenge;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_bit;
    logic [2:0]  rsp_ones;
    logic        PUF_RESET;
    logic [63:0] PUF_C;
    logic        PUF_OUT;

    logic        req_valid2;
    logic        req_ready2;
    logic [63:0] req_challenge2;
    logic        rsp_valid2;
    logic        rsp_ready2;
    logic        rsp_bit2;
    logic [0:0]  rsp_ones2;
    logic        PUF_RESET2;
    logic [63:0] PUF_C2;
    logic        PUF_OUT2;

`ifdef NBR_STABILITY_EN
    logic        rsp_stable;
    logic        rsp_stable2;
`endif

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       b;
        logic [2:0] ones;
        logic       st;
    } exp_t;

    exp_t sb[$];

    always #5 CLK = ~CLK;

    nbr64_eval_ctrl u_dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_challenge (req_challenge),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_bit       (rsp_bit),
        .rsp_ones      (rsp_ones),
`ifdef NBR_STABILITY_EN
        .rsp_stable    (rsp_stable),
`endif
        .PUF_RESET     (PUF_RESET),
        .PUF_C         (PUF_C),
        .PUF_OUT       (PUF_OUT)
    );

    nbr64_eval_ctrl #(
        .RESET_CYCLES  (1),
        .SETTLE_CYCLES (3),
        .NUM_EVAL      (1)
    ) u_dut2 (
        .CLK           (CLK),
        .RESET         (RESET),
        .req_valid     (req_valid2),
        .req_ready     (req_ready2),
        .req_challenge (req_challenge2),
        .rsp_valid     (rsp_valid2),
        .rsp_ready     (rsp_ready2),
        .rsp_bit       (rsp_bit2),
        .rsp_ones      (rsp_ones2),
`ifdef NBR_STABILITY_EN
        .rsp_stable    (rsp_stable2),
`endif
        .PUF_RESET     (PUF_RESET2),
        .PUF_C         (PUF_C2),
        .PUF_OUT       (PUF_OUT2)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic exp_t mk_exp(input logic [4:0] pat);
        exp_t e;
        int   c;
        c      = $countones(pat);
        e.ones = 3'(c);
        e.b    = (c > N / 2);
        e.st   = (c == 0) || (c == N);
        return e;
    endfunction

    // Issues one request and follows it to rsp_valid; returns observations only.
    task automatic run_req(
        input  logic [63:0] ch,
        input  logic [4:0]  pat,
        output int          lat,
        output int          pat_err,
        output int          rdy_err,
        output int          pc_err,
        output logic [63:0] c1
    );
        int w;
        w = 0;
        while (!req_ready && w < 200) begin
            step();
            w++;
        end
        req_valid     = 1'b1;
        req_challenge = ch;
        step();
        req_valid = 1'b0;
        c1        = PUF_C;
        lat       = 0;
        pat_err   = 0;
        rdy_err   = 0;
        pc_err    = 0;
        for (int n = 1; n <= LAT + 50; n++) begin
            int k;
            int ev;
            if (rsp_valid) begin
                lat = n;
                break;
            end
            k  = (n - 1) % EV;
            ev = (n - 1) / EV;
            if (PUF_RESET !== ((k < R) || (k == EV - 1))) pat_err++;
            if (req_ready !== 1'b0) rdy_err++;
            if (PUF_C !== ch) pc_err++;
            if (ev < N) PUF_OUT = pat[ev];
            step();
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step();
        step();
        total++;
        if (PUF_RESET !== 1'b1) begin
            bad++;
            $display("FAIL rst_puf_reset got=%b exp=1", PUF_RESET);
        end
        total++;
        if (PUF_C !== 64'h0) begin
            bad++;
            $display("FAIL rst_puf_c got=%h exp=0", PUF_C);
        end
        total++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_hs got=%b%b exp=00", req_ready, rsp_valid);
        end
        total++;
        if (rsp_bit !== 1'b0 || rsp_ones !== 3'd0) begin
            bad++;
            $display("FAIL rst_rsp got=%b/%0d exp=0/0", rsp_bit, rsp_ones);
        end
`ifdef NBR_STABILITY_EN
        total++;
        if (rsp_stable !== 1'b0) begin
            bad++;
            $display("FAIL rst_stable got=%b exp=0", rsp_stable);
        end
`endif
        RESET = 1'b0;
        step();
        total++;
        if (req_ready !== 1'b1 || req_ready2 !== 1'b1) begin
            bad++;
            $display("FAIL rst_ready_rise got=%b%b exp=11", req_ready, req_ready2);
        end
    endtask

    task automatic test_basic();
        exp_t        e;
        int          lat;
        int          pe;
        int          re;
        int          ce;
        logic [63:0] c1;
        sb.push_back(mk_exp(5'b11111));
        run_req(64'hDEADBEEF_01234567, 5'b11111, lat, pe, re, ce, c1);
        e = sb.pop_front();
        total++;
        if (c1 !== 64'hDEADBEEF_01234567) begin
            bad++;
            $display("FAIL basic_puf_c got=%h exp=deadbeef01234567", c1);
        end
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT);
        end
        total++;
        if (rsp_bit !== e.b || rsp_ones !== e.ones) begin
            bad++;
            $display("FAIL basic_rsp got=%b/%0d exp=%b/%0d", rsp_bit, rsp_ones, e.b, e.ones);
        end
`ifdef NBR_STABILITY_EN
        total++;
        if (rsp_stable !== e.st) begin
            bad++;
            $display("FAIL basic_stable got=%b exp=%b", rsp_stable, e.st);
        end
`endif
        total++;
        if (pe !== 0) begin
            bad++;
            $display("FAIL basic_puf_reset_wave got=%0d exp=0 errors", pe);
        end
        total++;
        if (re !== 0 || ce !== 0) begin
            bad++;
            $display("FAIL basic_busy got=%0d/%0d exp=0/0 errors", re, ce);
        end
        total++;
        if (PUF_RESET !== 1'b1) begin
            bad++;
            $display("FAIL basic_done_puf_reset got=%b exp=1", PUF_RESET);
        end
        step();
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || PUF_RESET !== 1'b1) begin
            bad++;
            $display("FAIL basic_idle got=%b%b%b exp=011", rsp_valid, req_ready, PUF_RESET);
        end
        total++;
        if (PUF_C !== 64'hDEADBEEF_01234567) begin
            bad++;
            $display("FAIL basic_idle_hold got=%h exp=deadbeef01234567", PUF_C);
        end
    endtask

    task automatic test_pattern();
        exp_t        e;
        int          lat;
        int          pe;
        int          re;
        int          ce;
        logic [63:0] c1;
        sb.push_back(mk_exp(5'b00101));
        run_req(64'h0123_4567_89AB_CDEF, 5'b00101, lat, pe, re, ce, c1);
        e = sb.pop_front();
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL pat_latency got=%0d exp=%0d", lat, LAT);
        end
        total++;
        if (rsp_bit !== e.b || rsp_ones !== e.ones) begin
            bad++;
            $display("FAIL pat_rsp got=%b/%0d exp=%b/%0d", rsp_bit, rsp_ones, e.b, e.ones);
        end
`ifdef NBR_STABILITY_EN
        total++;
        if (rsp_stable !== e.st) begin
            bad++;
            $display("FAIL pat_stable got=%b exp=%b", rsp_stable, e.st);
        end
`endif
        step();
    endtask

    task automatic test_hold();
        exp_t        e;
        int          lat;
        int          pe;
        int          re;
        int          ce;
        int          herr;
        logic [63:0] c1;
        logic [63:0] cha;
        logic [63:0] chb;
        cha       = 64'hA5A5_0000_FFFF_1234;
        chb       = 64'h5A5A_1111_2222_3333;
        rsp_ready = 1'b0;
        sb.push_back(mk_exp(5'b01101));
        run_req(cha, 5'b01101, lat, pe, re, ce, c1);
        e = sb.pop_front();
        total++;
        if (lat !== LAT || rsp_bit !== e.b || rsp_ones !== e.ones) begin
            bad++;
            $display("FAIL hold_first got=%0d/%b/%0d exp=%0d/%b/%0d",
                     lat, rsp_bit, rsp_ones, LAT, e.b, e.ones);
        end
        herr          = 0;
        req_valid     = 1'b1;
        req_challenge = chb;
        PUF_OUT       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_bit !== e.b || rsp_ones !== e.ones) herr++;
            if (req_ready !== 1'b0 || PUF_C !== cha) herr++;
        end
        total++;
        if (herr !== 0) begin
            bad++;
            $display("FAIL hold_stable got=%0d exp=0 errors", herr);
        end
        rsp_ready = 1'b1;
        step();
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release got=%b%b exp=01", rsp_valid, req_ready);
        end
        sb.push_back(mk_exp(5'b11111));
        step();
        req_valid = 1'b0;
        total++;
        if (PUF_C !== chb || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_second_accept got=%h/%b exp=%h/0", PUF_C, req_ready, chb);
        end
        lat = 0;
        for (int n = 1; n <= LAT + 50; n++) begin
            if (rsp_valid) begin
                lat = n;
                break;
            end
            step();
        end
        e = sb.pop_front();
        total++;
        if (lat !== LAT || rsp_ones !== e.ones || rsp_bit !== e.b) begin
            bad++;
            $display("FAIL hold_second_rsp got=%0d/%b/%0d exp=%0d/%b/%0d",
                     lat, rsp_bit, rsp_ones, LAT, e.b, e.ones);
        end
        step();
    endtask

    task automatic test_reset_mid();
        exp_t        e;
        int          lat;
        int          pe;
        int          re;
        int          ce;
        int          seen;
        logic [63:0] c1;
        req_valid     = 1'b1;
        req_challenge = 64'hFEED_FACE_CAFE_BEEF;
        PUF_OUT       = 1'b1;
        step();
        req_valid = 1'b0;
        for (int n = 1; n < 50; n++) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        total++;
        if (PUF_RESET !== 1'b1 || PUF_C !== 64'h0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got=%b/%h/%b exp=1/0/0", PUF_RESET, PUF_C, rsp_valid);
        end
        seen = 0;
        for (int n = 0; n < LAT + 20; n++) begin
            step();
            if (rsp_valid !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL mid_no_rsp got=%0d exp=0 valid cycles", seen);
        end
        sb.push_back(mk_exp(5'b11111));
        run_req(64'h1357_9BDF_0246_8ACE, 5'b11111, lat, pe, re, ce, c1);
        e = sb.pop_front();
        total++;
        if (lat !== LAT || rsp_ones !== e.ones || rsp_bit !== e.b) begin
            bad++;
            $display("FAIL mid_after got=%0d/%b/%0d exp=%0d/%b/%0d",
                     lat, rsp_bit, rsp_ones, LAT, e.b, e.ones);
        end
        step();
    endtask

    task automatic test_override();
        int lat;
        lat            = 0;
        req_valid2     = 1'b1;
        req_challenge2 = 64'h0000_0000_0000_00FF;
        step();
        req_valid2 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (rsp_valid2) begin
                lat = n;
                break;
            end
            step();
        end
        total++;
        if (lat !== 6) begin
            bad++;
            $display("FAIL ovr_latency got=%0d exp=6", lat);
        end
        total++;
        if (rsp_ones2 !== 1'b1 || rsp_bit2 !== 1'b1) begin
            bad++;
            $display("FAIL ovr_rsp got=%b/%0d exp=1/1", rsp_bit2, rsp_ones2);
        end
        total++;
        if (PUF_C2 !== 64'h0000_0000_0000_00FF) begin
            bad++;
            $display("FAIL ovr_puf_c got=%h exp=ff", PUF_C2);
        end
        step();
    endtask

    initial begin
        RESET          = 1'b1;
        req_valid      = 1'b0;
        req_challenge  = '0;
        rsp_ready      = 1'b1;
        PUF_OUT        = 1'b0;
        req_valid2     = 1'b0;
        req_challenge2 = '0;
        rsp_ready2     = 1'b1;
        PUF_OUT2       = 1'b1;
        test_reset();
        test_basic();
        test_pattern();
        test_hold();
        test_reset_mid();
        test_override();
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
